// File: rtl/othello_board_engine_if.sv
// rtl/othello_board_engine_if.sv - command, status and read-port bundle between control FSM and board engine
interface othello_board_engine_if;
  logic       restart;
  logic       detect;
  logic       place_disk;
  logic       turn_side;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  logic [2:0] rd_x;
  logic [2:0] rd_y;
  logic [1:0] rd_cell;
  logic       player;
  logic       busy;
  logic       done;
  logic       confirm;
  logic       win;
  logic [6:0] black_count;
  logic [6:0] white_count;

  modport master (
    output restart, detect, place_disk, turn_side, cur_x, cur_y, rd_x, rd_y,
    input  rd_cell, player, busy, done, confirm, win, black_count, white_count
  );

  modport slave (
    input  restart, detect, place_disk, turn_side, cur_x, cur_y, rd_x, rd_y,
    output rd_cell, player, busy, done, confirm, win, black_count, white_count
  );
endinterface

// File: rtl/othello_board_engine.sv
// rtl/othello_board_engine.sv - 8x8 Othello board datapath: legality scan, disk flip and disk count
module othello_board_engine #(
  parameter logic INIT_PLAYER = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  othello_board_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, FLIP, COUNT} state_t;

  state_t     state, state_next;
  logic [1:0] board [64];
  logic [2:0] px, py, dir;
  logic [3:0] cx, cy, k;
  logic       first;
  logic [2:0] ray_len [8];
  logic [7:0] ray_valid;
  logic [5:0] cnt_idx;
  logic [6:0] black_acc, white_acc, black_q, white_q;
  logic       player_q, confirm_q, win_q, done_q;

  function automatic logic [1:0] init_cell(input logic [5:0] i);
    case (i)
      6'd27, 6'd36: init_cell = 2'b10;
      6'd28, 6'd35: init_cell = 2'b01;
      default:      init_cell = 2'b00;
    endcase
  endfunction

  // Directions indexed N, NE, E, SE, S, SW, W, NW as 4-bit two's complement steps.
  function automatic logic [3:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dx = 4'b0001;
      3'd5, 3'd6, 3'd7: dir_dx = 4'b1111;
      default:          dir_dx = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd7, 3'd0, 3'd1: dir_dy = 4'b1111;
      3'd3, 3'd4, 3'd5: dir_dy = 4'b0001;
      default:          dir_dy = 4'b0000;
    endcase
  endfunction

  logic [1:0] own, opp, look, cnt_cell;
  logic [5:0] look_idx;
  logic       off_board, ray_done, ray_hit, scan_end, seg_done, flip_end, count_end;
  logic [7:0] mask_after;
  logic [2:0] next_dir, start_dir;
  logic [3:0] start_cx, start_cy;
  logic [6:0] black_sum, white_sum;

  always_comb begin
    own       = player_q ? 2'b10 : 2'b01;
    opp       = player_q ? 2'b01 : 2'b10;
    look_idx  = first ? {py, px} : {cy[2:0], cx[2:0]};
    look      = board[look_idx];
    // A sign bit set covers both -1 and +8 since a ray stops at its first off-board cell.
    off_board = cx[3] | cy[3];
    ray_done  = off_board || (look != opp);
    ray_hit   = !off_board && (look == own) && (k >= 4'd2);
    scan_end  = first ? (look != 2'b00) : (ray_done && (dir == 3'd7));
    seg_done  = first || (k == {1'b0, ray_len[dir]});
    mask_after = ray_valid;
    if (!first && seg_done) mask_after[dir] = 1'b0;
    flip_end  = seg_done && (mask_after == 8'd0);
    next_dir  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_after[i]) next_dir = 3'(i);
    end
    start_dir = (state == FLIP) ? next_dir : (first ? 3'd0 : dir + 3'd1);
    start_cx  = {1'b0, px} + dir_dx(start_dir);
    start_cy  = {1'b0, py} + dir_dy(start_dir);
    cnt_cell  = board[cnt_idx];
    black_sum = black_acc + {6'd0, cnt_cell == 2'b01};
    white_sum = white_acc + {6'd0, cnt_cell == 2'b10};
    count_end = (cnt_idx == 6'd63);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.place_disk && confirm_q) state_next = FLIP;
        else if (bus.detect)             state_next = SCAN;
      end
      SCAN:    if (scan_end)  state_next = IDLE;
      FLIP:    if (flip_end)  state_next = COUNT;
      COUNT:   if (count_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.restart) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) board[i] <= init_cell(6'(i));
      for (int i = 0; i < 8; i++) ray_len[i] <= 3'd0;
      {px, py, dir, cx, cy, k, first, ray_valid, cnt_idx} <= '0;
      {black_acc, white_acc} <= '0;
      black_q <= 7'd2;  white_q <= 7'd2;
      player_q <= INIT_PLAYER;
      {confirm_q, win_q, done_q} <= 3'b000;
    end else if (bus.restart) begin
      for (int i = 0; i < 64; i++) board[i] <= init_cell(6'(i));
      black_q <= 7'd2;  white_q <= 7'd2;
      player_q <= INIT_PLAYER;
      {confirm_q, win_q, done_q} <= 3'b000;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          first <= 1'b1;
          if (bus.place_disk && confirm_q) begin
            confirm_q <= 1'b0;
          end else if (bus.detect) begin
            px <= bus.cur_x;  py <= bus.cur_y;
            ray_valid <= 8'd0;
            for (int i = 0; i < 8; i++) ray_len[i] <= 3'd0;
            confirm_q <= 1'b0;
          end else if (bus.turn_side) begin
            player_q  <= ~player_q;
            confirm_q <= 1'b0;
          end
        end
        SCAN: begin
          first <= 1'b0;
          if (ray_hit && !first) begin
            ray_len[dir]   <= k[2:0] - 3'd1;
            ray_valid[dir] <= 1'b1;
          end
          if (scan_end) begin
            done_q    <= 1'b1;
            confirm_q <= !first && ((|ray_valid) || ray_hit);
          end else if (first || ray_done) begin
            dir <= start_dir;  k <= 4'd1;  cx <= start_cx;  cy <= start_cy;
          end else begin
            k <= k + 4'd1;  cx <= cx + dir_dx(dir);  cy <= cy + dir_dy(dir);
          end
        end
        FLIP: begin
          first <= 1'b0;
          board[look_idx] <= own;
          if (seg_done) begin
            ray_valid <= mask_after;
            dir <= start_dir;  k <= 4'd1;  cx <= start_cx;  cy <= start_cy;
            cnt_idx <= 6'd0;  black_acc <= 7'd0;  white_acc <= 7'd0;
          end else begin
            k <= k + 4'd1;  cx <= cx + dir_dx(dir);  cy <= cy + dir_dy(dir);
          end
        end
        COUNT: begin
          cnt_idx   <= cnt_idx + 6'd1;
          black_acc <= black_sum;
          white_acc <= white_sum;
          if (count_end) begin
            black_q <= black_sum;
            white_q <= white_sum;
            win_q   <= win_q || (black_sum + white_sum == 7'd64) ||
                       (black_sum == 7'd0) || (white_sum == 7'd0);
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_cell     = board[{bus.rd_y, bus.rd_x}];
  assign bus.player      = player_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.confirm     = confirm_q;
  assign bus.win         = win_q;
  assign bus.black_count = black_q;
  assign bus.white_count = white_q;
endmodule
